// File: rtl/seg_score_display.sv
// Seven-segment driver for the whack-a-mole game: sequential double-dabble BCD conversion of
// score and time, four-digit scan with one-clock anti-ghost blanking, PLAY/OVER/IDLE modes.
module seg_score_display #(
    parameter int unsigned BLINK_TICKS = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_clk_i,
    input  logic       game_active_i,
    input  logic       game_over_i,
    input  logic [5:0] score_i,
    input  logic [6:0] time_left_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [3:0] an_o,
    output logic       conv_busy_o
);
    localparam int unsigned BIN_W   = 7;
    localparam int unsigned BCD_W   = 8;
    localparam int unsigned DD_W    = BIN_W + BCD_W;
    localparam int unsigned SHIFTS  = 7;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_PLAY = 2'd1;
    localparam logic [1:0] MODE_OVER = 2'd2;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [6:0] SEG_DASH   = 7'b0111111;
    localparam logic [2:0] LAST_SHIFT = 3'(SHIFTS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    logic              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, tick_q, tick_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic [1:0]        state_q, state_d;
    logic [2:0]        shift_cnt_q, shift_cnt_d;
    logic [5:0]        snap_score_q, snap_score_d;
    logic [6:0]        snap_time_q, snap_time_d;
    logic [DD_W-1:0]   t_dd_q, t_dd_d, s_dd_q, s_dd_d;
    logic [3:0]        time_tens_q, time_tens_d, time_ones_q, time_ones_d;
    logic [3:0]        score_tens_q, score_tens_d, score_ones_q, score_ones_d;
    logic              busy_q, busy_d;
    logic [1:0]        mode_q, mode_d;
    logic              blink_on_q, blink_on_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic [6:0]        time_sat;
    logic [3:0]        digit;
    logic              blink_vis;

    // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift left.
    function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] v);
        logic [DD_W-1:0] a;
        a = v;
        if (a[14:11] >= 4'd5) a[14:11] = a[14:11] + 4'd3;
        if (a[10:7]  >= 4'd5) a[10:7]  = a[10:7]  + 4'd3;
        return {a[DD_W-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        sync1_d      = scan_clk_i;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        tick_d       = sync2_q & ~prev_q;
        digit_idx_d  = digit_idx_q;
        state_d      = state_q;
        shift_cnt_d  = shift_cnt_q;
        snap_score_d = snap_score_q;
        snap_time_d  = snap_time_q;
        t_dd_d       = t_dd_q;
        s_dd_d       = s_dd_q;
        time_tens_d  = time_tens_q;
        time_ones_d  = time_ones_q;
        score_tens_d = score_tens_q;
        score_ones_d = score_ones_q;
        mode_d       = MODE_IDLE;
        blink_on_d   = blink_on_q;
        blink_cnt_d  = blink_cnt_q;
        an_d         = 4'b1111;
        seg_d        = SEG_BLANK;
        dp_d         = 1'b1;
        digit        = score_ones_q;

        time_sat = (time_left_i > 7'd99) ? 7'd99 : time_left_i;

        if (tick_q) digit_idx_d = digit_idx_q + 2'd1;

        // Converter: snapshot compare, 7 shifts, then an atomic commit of all four digits.
        case (state_q)
            ST_IDLE: begin
                if ({score_i, time_sat} != {snap_score_q, snap_time_q}) begin
                    snap_score_d = score_i;
                    snap_time_d  = time_sat;
                    t_dd_d       = {BCD_W'(0), time_sat};
                    s_dd_d       = {BCD_W'(0), 1'b0, score_i};
                    shift_cnt_d  = 3'd0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                t_dd_d      = dabble_step(t_dd_q);
                s_dd_d      = dabble_step(s_dd_q);
                shift_cnt_d = shift_cnt_q + 3'd1;
                if (shift_cnt_q == LAST_SHIFT) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                time_tens_d  = t_dd_q[14:11];
                time_ones_d  = t_dd_q[10:7];
                score_tens_d = s_dd_q[14:11];
                score_ones_d = s_dd_q[10:7];
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);

        if (game_active_i)    mode_d = MODE_PLAY;
        else if (game_over_i) mode_d = MODE_OVER;

        // Blink restarts visible on every entry into OVER.
        if (mode_d == MODE_OVER) begin
            if (mode_q != MODE_OVER) begin
                blink_on_d  = 1'b1;
                blink_cnt_d = '0;
            end else if (tick_q) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_on_d  = ~blink_on_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
        end
        blink_vis = (mode_q != MODE_OVER) || blink_on_q;

        case (digit_idx_q)
            2'd3:    digit = time_tens_q;
            2'd2:    digit = time_ones_q;
            2'd1:    digit = score_tens_q;
            default: digit = score_ones_q;
        endcase

        // The clock in which digit_idx advances stays dark to avoid ghosting.
        if (!tick_q) begin
            an_d = ~(4'b0001 << digit_idx_q);
            case (mode_d)
                MODE_PLAY: begin
                    if (digit_idx_q == 2'd3 && digit == 4'd0) seg_d = SEG_BLANK;
                    else                                      seg_d = seg_decode(digit);
                end
                MODE_OVER: begin
                    if (digit_idx_q[1])  seg_d = seg_decode(4'd0);
                    else if (blink_vis)  seg_d = seg_decode(digit);
                    else                 an_d  = 4'b1111;
                end
                default: seg_d = SEG_DASH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            tick_q       <= 1'b0;
            digit_idx_q  <= 2'd0;
            state_q      <= ST_IDLE;
            shift_cnt_q  <= 3'd0;
            snap_score_q <= 6'd0;
            snap_time_q  <= 7'd0;
            t_dd_q       <= '0;
            s_dd_q       <= '0;
            time_tens_q  <= 4'd0;
            time_ones_q  <= 4'd0;
            score_tens_q <= 4'd0;
            score_ones_q <= 4'd0;
            busy_q       <= 1'b0;
            mode_q       <= MODE_IDLE;
            blink_on_q   <= 1'b1;
            blink_cnt_q  <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            tick_q       <= tick_d;
            digit_idx_q  <= digit_idx_d;
            state_q      <= state_d;
            shift_cnt_q  <= shift_cnt_d;
            snap_score_q <= snap_score_d;
            snap_time_q  <= snap_time_d;
            t_dd_q       <= t_dd_d;
            s_dd_q       <= s_dd_d;
            time_tens_q  <= time_tens_d;
            time_ones_q  <= time_ones_d;
            score_tens_q <= score_tens_d;
            score_ones_q <= score_ones_d;
            busy_q       <= busy_d;
            mode_q       <= mode_d;
            blink_on_q   <= blink_on_d;
            blink_cnt_q  <= blink_cnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign seg_o       = seg_q;
    assign dp_o        = dp_q;
    assign an_o        = an_q;
    assign conv_busy_o = busy_q;

endmodule
